// File: rtl/imm_pkg.sv
// imm_pkg: shared formats, NOP encoding, immediate range bounds and the range/alignment check
package imm_pkg;
  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;
  localparam logic [2:0] FMT_R = 3'd5;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int IS_MIN = -2048;
  localparam int IS_MAX = 2047;
  localparam int B_MIN = -4096;
  localparam int B_MAX = 4094;
  localparam int J_MIN = -1048576;
  localparam int J_MAX = 1048574;
  function automatic logic imm_err(input logic [2:0] fmt, input logic [31:0] imm);
    int s;
    s = $signed(imm);
    return (fmt == FMT_I || fmt == FMT_S) ? (s < IS_MIN || s > IS_MAX) :
           fmt == FMT_B ? (imm[0] || s < B_MIN || s > B_MAX) :
           fmt == FMT_U ? |imm[11:0] :
           fmt == FMT_J ? (imm[0] || s < J_MIN || s > J_MAX) :
           fmt != FMT_R;
  endfunction
endpackage

// File: rtl/imm_field_pack.sv
// imm_field_pack: combinational scatter of immediate and register fields into a RISC-V word
module imm_field_pack
  import imm_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] imm,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [6:0]  opcode,
  output logic [31:0] inst
);
  always_comb begin
    inst = fmt == FMT_I ? {imm[11:0], rs1, funct3, rd, opcode} :
           fmt == FMT_S ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} :
           fmt == FMT_B ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode} :
           fmt == FMT_U ? {imm[31:12], rd, opcode} :
           fmt == FMT_J ? {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode} :
           fmt == FMT_R ? {funct7, rs2, rs1, funct3, rd, opcode} :
           NOP_INST;
  end
endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage check/pack RISC-V encoder with valid/ready handshakes and saturating error count
module imm_encoder
  import imm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [31:0]      in_imm,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [6:0]       in_opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);
  logic s1_valid, s1_err, s1_adv, s2_adv;
  logic [2:0] s1_fmt, s1_f3;
  logic [31:0] s1_imm, packed_inst;
  logic [4:0] s1_rd, s1_rs1, s1_rs2;
  logic [6:0] s1_f7, s1_op;
  assign s2_adv = !out_valid || out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign in_ready = s1_adv && !rst;
  imm_field_pack u_pack (
    .fmt(s1_fmt), .imm(s1_imm), .rd(s1_rd), .rs1(s1_rs1), .rs2(s1_rs2),
    .funct3(s1_f3), .funct7(s1_f7), .opcode(s1_op), .inst(packed_inst)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_err <= 1'b0;
      s1_fmt <= '0;
      s1_imm <= '0;
      s1_rd <= '0;
      s1_rs1 <= '0;
      s1_rs2 <= '0;
      s1_f3 <= '0;
      s1_f7 <= '0;
      s1_op <= '0;
      out_valid <= 1'b0;
      out_inst <= '0;
      out_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        s1_err <= imm_err(in_fmt, in_imm);
        s1_fmt <= in_fmt;
        s1_imm <= in_imm;
        s1_rd <= in_rd;
        s1_rs1 <= in_rs1;
        s1_rs2 <= in_rs2;
        s1_f3 <= in_funct3;
        s1_f7 <= in_funct7;
        s1_op <= in_opcode;
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        out_inst <= s1_err ? NOP_INST : packed_inst;
        out_err <= s1_err;
      end
      if (out_valid && out_ready && out_err && err_cnt != '1)
        err_cnt <= err_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed and randomized checks of imm_encoder against an arithmetic encoding model
module tb_imm_encoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, in_valid, out_ready;
  logic [2:0] in_fmt, in_funct3;
  logic [31:0] in_imm;
  logic [4:0] in_rd, in_rs1, in_rs2;
  logic [6:0] in_funct7, in_opcode;
  logic in_ready, out_valid, out_err, in_ready2, out_valid2, out_err2;
  logic [31:0] out_inst, out_inst2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  imm_encoder #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_imm(in_imm),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_opcode(in_opcode), .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .err_cnt(err_cnt)
  );
  imm_encoder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_fmt(in_fmt), .in_imm(in_imm),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_opcode(in_opcode), .out_valid(out_valid2), .out_ready(out_ready), .out_inst(out_inst2),
    .out_err(out_err2), .err_cnt(err_cnt2)
  );
  int checks = 0, failures = 0, model_cnt = 0, model_cnt2 = 0;
  logic [32:0] exp_q[$];
  logic s_fi, s_fo, s_ov, s_ir, s_err;
  logic [31:0] s_inst;
  logic [7:0] s_cnt;
  logic [1:0] s_cnt2;
  int bnd[14] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4096, -4098, -1048576, 1048574, 1048576, 0, 1, 4095};
  function automatic logic [32:0] model(input logic [2:0] fmt, input logic [31:0] imm, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [6:0] op);
    int s;
    logic e;
    logic [31:0] w, base, rdf;
    s = $signed(imm);
    base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    rdf = 32'(rd) << 7;
    e = 1'b1;
    w = 32'h13;
    case (fmt)
      3'd0: begin
        e = s < -2048 || s > 2047;
        w = ((imm & 32'hFFF) << 20) | base | rdf;
      end
      3'd1: begin
        e = s < -2048 || s > 2047;
        w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | base | ((imm & 32'h1F) << 7);
      end
      3'd2: begin
        e = (imm % 2 != 0) || s < -4096 || s > 4094;
        w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20) | base
          | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
      end
      3'd3: begin
        e = (imm & 32'hFFF) != 0;
        w = (imm & 32'hFFFF_F000) | rdf | 32'(op);
      end
      3'd4: begin
        e = (imm % 2 != 0) || s < -1048576 || s > 1048574;
        w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
          | (((imm >> 12) & 32'hFF) << 12) | rdf | 32'(op);
      end
      3'd5: begin
        e = 1'b0;
        w = (32'(f7) << 25) | (32'(rs2) << 20) | base | rdf;
      end
      default: ;
    endcase
    return {e, e ? 32'h13 : w};
  endfunction
  task automatic tick();
    @(negedge clk);
    s_fi = in_valid && in_ready;
    s_fo = out_valid && out_ready;
    s_ov = out_valid;
    s_ir = in_ready;
    s_inst = out_inst;
    s_err = out_err;
    s_cnt = err_cnt;
    s_cnt2 = err_cnt2;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [2:0] f, input logic [31:0] imm, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [6:0] op);
    in_fmt = f; in_imm = imm; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_opcode = op;
  endtask
  task automatic drive_rand();
    logic [31:0] imm;
    case ($urandom_range(0, 3))
      0: imm = $urandom;
      1: imm = 32'($signed($urandom_range(0, 8191)) - 4096);
      2: imm = 32'(bnd[$urandom_range(0, 13)]);
      default: imm = $urandom & 32'hFFFF_F000;
    endcase
    drive(3'($urandom_range(0, 7)), imm, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
          7'($urandom), 7'($urandom));
  endtask
  task automatic push_model();
    exp_q.push_back(model(in_fmt, in_imm, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_opcode));
  endtask
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(3'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 7'd0);
    @(posedge clk);
    #1;
    tick();
    tick();
    checks++; if (s_ir !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", s_ir); end
    checks++; if (s_ov !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", s_ov); end
    checks++; if (s_inst !== 32'h0) begin failures++; $display("FAIL reset_out_inst got=%h exp=0", s_inst); end
    checks++; if (s_err !== 1'b0) begin failures++; $display("FAIL reset_out_err got=%b exp=0", s_err); end
    checks++; if (s_cnt !== 8'd0 || s_cnt2 !== 2'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d/%0d exp=0", s_cnt, s_cnt2); end
    rst = 1'b0;
    tick();
    checks++; if (s_ir !== 1'b1) begin failures++; $display("FAIL idle_in_ready got=%b exp=1", s_ir); end
  endtask
  task automatic test_directed();
    logic [2:0] vf[8] = '{3'd0, 3'd1, 3'd4, 3'd2, 3'd0, 3'd7, 3'd3, 3'd5};
    logic [31:0] vi[8] = '{32'hFFFF_FFFF, 32'd8, 32'hFFFF_FFFC, 32'd3, 32'd2048, 32'd0, 32'h1234_5000, 32'd0};
    logic [4:0] vrd[8] = '{5'd1, 5'd0, 5'd1, 5'd0, 5'd1, 5'd3, 5'd5, 5'd1};
    logic [4:0] vr1[8] = '{5'd0, 5'd3, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd2};
    logic [4:0] vr2[8] = '{5'd0, 5'd2, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd3};
    logic [2:0] vf3[8] = '{3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0};
    logic [6:0] vf7[8] = '{7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'h7F, 7'd0, 7'h20};
    logic [6:0] vop[8] = '{7'h13, 7'h23, 7'h6F, 7'h63, 7'h13, 7'h33, 7'h37, 7'h33};
    logic [31:0] vx[8] = '{32'hFFF0_0093, 32'h0021_A423, 32'hFFDF_F0EF, 32'h13, 32'h13, 32'h13, 32'h1234_52B7, 32'h4031_00B3};
    logic ve[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(vf[i], vi[i], vrd[i], vr1[i], vr2[i], vf3[i], vf7[i], vop[i]);
      in_valid = 1'b1;
      tick();
      checks++; if (s_fi !== 1'b1) begin failures++; $display("FAIL dir%0d_accept got=%b exp=1", i, s_fi); end
      checks++; if (s_cnt !== 8'(model_cnt)) begin failures++; $display("FAIL dir%0d_err_cnt got=%0d exp=%0d", i, s_cnt, model_cnt); end
      in_valid = 1'b0;
      tick();
      checks++; if (s_ov !== 1'b0) begin failures++; $display("FAIL dir%0d_early_valid got=%b exp=0", i, s_ov); end
      tick();
      checks++; if (s_ov !== 1'b1) begin failures++; $display("FAIL dir%0d_latency got=%b exp=1", i, s_ov); end
      checks++; if (s_inst !== vx[i] || s_err !== ve[i]) begin failures++; $display("FAIL dir%0d_inst got=%h/%b exp=%h/%b", i, s_inst, s_err, vx[i], ve[i]); end
      if (ve[i]) begin
        model_cnt = model_cnt < 255 ? model_cnt + 1 : 255;
        model_cnt2 = model_cnt2 < 3 ? model_cnt2 + 1 : 3;
      end
    end
    tick();
    checks++; if (s_cnt !== 8'd3) begin failures++; $display("FAIL dir_err_cnt_total got=%0d exp=3", s_cnt); end
  endtask
  task automatic test_saturate();
    logic [32:0] e;
    out_ready = 1'b1;
    drive(3'd6, $urandom, 5'd1, 5'd2, 5'd3, 3'd4, 7'd5, 7'h13);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 6) in_valid = 1'b0;
      tick();
      if (s_fo) begin
        if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL sat_extra_output got=%h exp=none", s_inst); end
        else begin
          e = exp_q.pop_front();
          checks++; if ({s_err, s_inst} !== e) begin failures++; $display("FAIL sat_output got=%b/%h exp=%b/%h", s_err, s_inst, e[32], e[31:0]); end
          if (e[32]) begin
            model_cnt = model_cnt < 255 ? model_cnt + 1 : 255;
            model_cnt2 = model_cnt2 < 3 ? model_cnt2 + 1 : 3;
          end
        end
      end
      if (s_fi) push_model();
    end
    tick();
    checks++; if (s_cnt2 !== 2'd3) begin failures++; $display("FAIL sat_cnt_w2 got=%0d exp=3", s_cnt2); end
    checks++; if (s_cnt !== 8'(model_cnt)) begin failures++; $display("FAIL sat_cnt_w8 got=%0d exp=%0d", s_cnt, model_cnt); end
  endtask
  task automatic test_back_to_back();
    logic [32:0] e;
    logic [31:0] held;
    int idx = 0, outs = 0;
    logic [31:0] ri[3] = '{32'd100, 32'hFFFF_FF00, 32'd2047};
    out_ready = 1'b0;
    held = 32'h0;
    for (int i = 0; i < 5; i++) begin
      in_valid = idx < 3;
      drive(3'd0, ri[idx % 3], 5'(idx + 1), 5'd7, 5'd0, 3'd0, 7'd0, 7'h13);
      tick();
      if (s_ov && held == 32'h0) held = s_inst;
      else if (s_ov) begin
        checks++; if (s_inst !== held) begin failures++; $display("FAIL stall_hold got=%h exp=%h", s_inst, held); end
      end
      if (s_fi) begin push_model(); idx++; end
    end
    checks++; if (idx !== 2) begin failures++; $display("FAIL stall_accepts got=%0d exp=2", idx); end
    checks++; if (s_ir !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b exp=0", s_ir); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = idx < 3;
      drive(3'd0, ri[idx % 3], 5'(idx + 1), 5'd7, 5'd0, 3'd0, 7'd0, 7'h13);
      tick();
      if (s_fo) begin
        outs++;
        if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL bp_extra_output got=%h exp=none", s_inst); end
        else begin
          e = exp_q.pop_front();
          checks++; if ({s_err, s_inst} !== e) begin failures++; $display("FAIL bp_order got=%b/%h exp=%b/%h", s_err, s_inst, e[32], e[31:0]); end
        end
      end
      if (s_fi) begin push_model(); idx++; end
    end
    checks++; if (outs !== 3 || exp_q.size() !== 0) begin failures++; $display("FAIL bp_count got=%0d left=%0d exp=3/0", outs, exp_q.size()); end
  endtask
  task automatic test_random();
    logic [32:0] e;
    for (int i = 0; i < 420; i++) begin
      in_valid = i < 400 && $urandom_range(0, 9) < 7;
      out_ready = i >= 400 || $urandom_range(0, 9) < 7;
      drive_rand();
      tick();
      checks++; if (s_cnt !== 8'(model_cnt) || s_cnt2 !== 2'(model_cnt2)) begin failures++; $display("FAIL rnd_err_cnt got=%0d/%0d exp=%0d/%0d", s_cnt, s_cnt2, model_cnt, model_cnt2); end
      if (s_fo) begin
        if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL rnd_extra_output got=%h exp=none", s_inst); end
        else begin
          e = exp_q.pop_front();
          checks++; if ({s_err, s_inst} !== e) begin failures++; $display("FAIL rnd_output got=%b/%h exp=%b/%h", s_err, s_inst, e[32], e[31:0]); end
          if (e[32]) begin
            model_cnt = model_cnt < 255 ? model_cnt + 1 : 255;
            model_cnt2 = model_cnt2 < 3 ? model_cnt2 + 1 : 3;
          end
        end
      end
      if (s_fi) push_model();
    end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL rnd_drain got=%0d left exp=0", exp_q.size()); end
  endtask
  task automatic test_reset_mid();
    logic [32:0] e;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(3'd6, 32'd0, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 7'h13);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    checks++; if (s_ir !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", s_ir); end
    rst = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    model_cnt2 = 0;
    out_ready = 1'b1;
    tick();
    checks++; if (s_ov !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", s_ov); end
    checks++; if (s_cnt !== 8'd0 || s_cnt2 !== 2'd0) begin failures++; $display("FAIL rst_mid_cnt got=%0d/%0d exp=0", s_cnt, s_cnt2); end
    drive(3'd1, 32'hFFFF_FFF0, 5'd0, 5'd9, 5'd10, 3'd2, 7'd0, 7'h23);
    e = model(in_fmt, in_imm, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_opcode);
    in_valid = 1'b1;
    tick();
    checks++; if (s_fi !== 1'b1) begin failures++; $display("FAIL rst_fresh_accept got=%b exp=1", s_fi); end
    in_valid = 1'b0;
    tick();
    checks++; if (s_ov !== 1'b0) begin failures++; $display("FAIL rst_fresh_early got=%b exp=0", s_ov); end
    tick();
    checks++; if (s_ov !== 1'b1 || {s_err, s_inst} !== e) begin failures++; $display("FAIL rst_fresh_out got=%b %b/%h exp=1 %b/%h", s_ov, s_err, s_inst, e[32], e[31:0]); end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_saturate();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
